// File: rtl/epmp_mem_arbiter_pkg.sv
// Shared encodings for the EPMP memory arbiter: FSM states and grant owners.
package epmp_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/epmp_arb_timer.sv
// Access watchdog: down-counter loaded on clear, expires on its last enabled
// cycle so that exactly TIMEOUT enabled cycles elapse before o_expired.
module epmp_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic nReset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Load on clear, count down while enabled, hold at zero.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/epmp_mem_arbiter.sv
// Shares one memory port between CU memory strobes and the debug host.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no cycle in flight; pick debug or CPU, latch request
// ACCESS  | Mem_CS high, waiting for Mem_Ready or the watchdog
// RELEASE | one dead cycle; ack the debug owner or unstall the CPU
module epmp_mem_arbiter
  import epmp_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              CPU_Read,
  input  logic              CPU_Write,
  input  logic [ADDR_W-1:0] CPU_Addr,
  input  logic [DATA_W-1:0] CPU_WData,
  output logic [DATA_W-1:0] CPU_RData,
  output logic              CPU_Wait,
  input  logic              Dbg_Req,
  input  logic              Dbg_We,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  input  logic [DATA_W-1:0] Dbg_WData,
  output logic [DATA_W-1:0] Dbg_RData,
  output logic              Dbg_Ack,
  output logic              Mem_CS,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic [DATA_W-1:0] Mem_RData,
  input  logic              Mem_Ready,
  input  logic              Err_Clr,
  output logic              Bus_Error,
  output logic [1:0]        Grant_Owner
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic [SW-1:0]     r_starve;
  logic              r_bus_err;

  logic w_cpu_req;
  logic w_dbg_win;
  logic w_cpu_win;
  logic w_grant;
  logic w_in_access;
  logic w_tmo_exp;
  logic w_rd_done;
  logic w_err_set;

  assign w_cpu_req   = CPU_Read | CPU_Write;
  assign w_dbg_win   = Dbg_Req && (!w_cpu_req || (r_starve == SW'(STARVE_LIM)));
  assign w_cpu_win   = w_cpu_req && !w_dbg_win;
  assign w_grant     = (r_state == ST_IDLE) && (w_dbg_win || w_cpu_win);
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_rd_done   = w_in_access && Mem_Ready && !r_we;
  // Conflicting CU strobes are flagged at grant; a ready on the final
  // watchdog cycle still counts as a good completion.
  assign w_err_set   = ((r_state == ST_IDLE) && w_cpu_win && CPU_Read && CPU_Write)
                     || (w_in_access && !Mem_Ready && w_tmo_exp);

  epmp_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .nReset    (nReset),
    .i_clr     (w_grant),
    .i_en      (w_in_access),
    .o_expired (w_tmo_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_dbg_win || w_cpu_win) w_state_nxt = ST_ACCESS;
      ST_ACCESS:  if (Mem_Ready || w_tmo_exp) w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory strobes, handshakes and stall; CPU_Wait is gated by reset so the
  // stall drops the instant nReset asserts.
  always_comb begin
    Mem_CS      = w_in_access;
    Mem_WE      = w_in_access && r_we;
    Dbg_Ack     = (r_state == ST_RELEASE) && (r_owner == OWN_DBG);
    CPU_Wait    = nReset && w_cpu_req && !((r_state == ST_RELEASE) && (r_owner == OWN_CPU));
    Grant_Owner = (r_state == ST_IDLE) ? 2'(OWN_NONE) : 2'(r_owner);
  end

  // Latch the winning request so the memory sees stable address/data.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_dbg_win) begin
        r_owner <= OWN_DBG;
        r_addr  <= Dbg_Addr;
        r_wdata <= Dbg_WData;
        r_we    <= Dbg_We;
      end else if (w_cpu_win) begin
        r_owner <= OWN_CPU;
        r_addr  <= CPU_Addr;
        r_wdata <= CPU_WData;
        r_we    <= CPU_Write;
      end
    end
  end

  // Read data capture into the owner's register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else if (w_rd_done) begin
      if (r_owner == OWN_CPU)      r_cpu_rdata <= Mem_RData;
      else if (r_owner == OWN_DBG) r_dbg_rdata <= Mem_RData;
    end
  end

  // Starvation counter: counts CPU grants that bypassed a pending debug request.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_starve <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!Dbg_Req || w_dbg_win)                           r_starve <= '0;
      else if (w_cpu_win && (r_starve != SW'(STARVE_LIM))) r_starve <= r_starve + 1'b1;
    end
  end

  // Sticky bus error; a set in the same cycle as Err_Clr wins.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)        r_bus_err <= 1'b0;
    else if (w_err_set) r_bus_err <= 1'b1;
    else if (Err_Clr)   r_bus_err <= 1'b0;
  end

  assign CPU_RData = r_cpu_rdata;
  assign Dbg_RData = r_dbg_rdata;
  assign Mem_Addr  = r_addr;
  assign Mem_WData = r_wdata;
  assign Bus_Error = r_bus_err;

endmodule

// File: tb/tb_epmp_mem_arbiter.sv
// Directed bench for epmp_mem_arbiter with hand-computed expectations.
module tb_epmp_mem_arbiter;

  logic       clk = 1'b0;
  logic       nReset;
  logic       CPU_Read, CPU_Write;
  logic [7:0] CPU_Addr, CPU_WData, CPU_RData;
  logic       CPU_Wait;
  logic       Dbg_Req, Dbg_We;
  logic [7:0] Dbg_Addr, Dbg_WData, Dbg_RData;
  logic       Dbg_Ack;
  logic       Mem_CS, Mem_WE;
  logic [7:0] Mem_Addr, Mem_WData, Mem_RData;
  logic       Mem_Ready;
  logic       Err_Clr;
  logic       Bus_Error;
  logic [1:0] Grant_Owner;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc;

  always #5 clk = ~clk;

  epmp_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIM(4), .TIMEOUT(15)) dut (
    .clk(clk), .nReset(nReset),
    .CPU_Read(CPU_Read), .CPU_Write(CPU_Write), .CPU_Addr(CPU_Addr),
    .CPU_WData(CPU_WData), .CPU_RData(CPU_RData), .CPU_Wait(CPU_Wait),
    .Dbg_Req(Dbg_Req), .Dbg_We(Dbg_We), .Dbg_Addr(Dbg_Addr),
    .Dbg_WData(Dbg_WData), .Dbg_RData(Dbg_RData), .Dbg_Ack(Dbg_Ack),
    .Mem_CS(Mem_CS), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ready(Mem_Ready),
    .Err_Clr(Err_Clr), .Bus_Error(Bus_Error), .Grant_Owner(Grant_Owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nReset = 1'b0; CPU_Read = 1'b1; CPU_Write = 1'b0; CPU_Addr = 8'h00; CPU_WData = 8'h00;
    Dbg_Req = 1'b0; Dbg_We = 1'b0; Dbg_Addr = 8'h00; Dbg_WData = 8'h00;
    Mem_RData = 8'h00; Mem_Ready = 1'b1; Err_Clr = 1'b0;
    #12;
    chk("rst_cs", Mem_CS, 1'b0);
    chk("rst_wait_gated", CPU_Wait, 1'b0);
    chk("rst_owner", Grant_Owner, 2'd0);
    chk("rst_ack", Dbg_Ack, 1'b0);
    chk("rst_err", Bus_Error, 1'b0);
    chk("rst_cpu_rdata", CPU_RData, 8'h00);
    chk("rst_dbg_rdata", Dbg_RData, 8'h00);
    CPU_Read = 1'b0;
    tick();
    nReset = 1'b1;

    // CPU read at 0x3C, ready immediately.
    CPU_Read = 1'b1; CPU_Addr = 8'h3C; Mem_RData = 8'hA5; #1;
    chk("c0_wait", CPU_Wait, 1'b1);
    chk("c0_owner", Grant_Owner, 2'd0);
    chk("c0_cs", Mem_CS, 1'b0);
    tick(); #1;
    chk("c1_cs", Mem_CS, 1'b1);
    chk("c1_we", Mem_WE, 1'b0);
    chk("c1_addr", Mem_Addr, 8'h3C);
    chk("c1_wait", CPU_Wait, 1'b1);
    chk("c1_owner", Grant_Owner, 2'd1);
    tick(); #1;
    chk("c2_wait", CPU_Wait, 1'b0);
    chk("c2_rdata", CPU_RData, 8'hA5);
    chk("c2_owner", Grant_Owner, 2'd1);
    chk("c2_cs", Mem_CS, 1'b0);
    CPU_Read = 1'b0;
    tick(); #1;
    chk("c3_owner", Grant_Owner, 2'd0);

    // Debug write 0x5A to 0x10.
    Dbg_Req = 1'b1; Dbg_We = 1'b1; Dbg_Addr = 8'h10; Dbg_WData = 8'h5A; #1;
    chk("d0_ack", Dbg_Ack, 1'b0);
    tick(); #1;
    chk("d1_we", Mem_WE, 1'b1);
    chk("d1_addr", Mem_Addr, 8'h10);
    chk("d1_wdata", Mem_WData, 8'h5A);
    chk("d1_owner", Grant_Owner, 2'd2);
    chk("d1_ack", Dbg_Ack, 1'b0);
    tick(); #1;
    chk("d2_ack", Dbg_Ack, 1'b1);
    Dbg_Req = 1'b0; Dbg_We = 1'b0;
    tick(); #1;
    chk("d3_ack", Dbg_Ack, 1'b0);
    chk("d3_dbg_rdata", Dbg_RData, 8'h00);

    // Starvation: CPU reads held, debug read pending.
    CPU_Read = 1'b1; CPU_Addr = 8'h44; Dbg_Req = 1'b1; Dbg_Addr = 8'h77; Mem_RData = 8'h11;
    for (int g = 0; g < 4; g++) begin
      tick(); #1;
      chk($sformatf("st_cpu_grant%0d", g), Grant_Owner, 2'd1);
      tick(); #1;
      chk($sformatf("st_cpu_rel%0d", g), CPU_Wait, 1'b0);
      tick();
    end
    #1;
    tick(); #1;
    chk("st_dbg_grant", Grant_Owner, 2'd2);
    chk("st_dbg_addr", Mem_Addr, 8'h77);
    chk("st_cpu_stalled", CPU_Wait, 1'b1);
    tick(); #1;
    chk("st_dbg_ack", Dbg_Ack, 1'b1);
    chk("st_dbg_rdata", Dbg_RData, 8'h11);
    chk("st_cpu_rdata", CPU_RData, 8'h11);
    tick(); #1;
    // Debug grant cleared the counter: CPU wins the next contested IDLE.
    tick(); #1;
    chk("st_cleared", Grant_Owner, 2'd1);
    tick(); #1;
    CPU_Read = 1'b0; Dbg_Req = 1'b0;
    tick(); #1;
    tick(); #1;
    chk("drop_before_grant_cs", Mem_CS, 1'b0);
    chk("drop_before_grant_owner", Grant_Owner, 2'd0);

    // Timeout: Mem_Ready held low on a CPU write.
    Mem_Ready = 1'b0; CPU_Write = 1'b1; CPU_Addr = 8'h20; CPU_WData = 8'h99;
    tick(); #1;
    n_acc = 0;
    while (Mem_CS && n_acc < 20) begin
      n_acc++;
      tick(); #1;
    end
    chk("tmo_len", n_acc, 15);
    chk("tmo_err", Bus_Error, 1'b1);
    chk("tmo_wait", CPU_Wait, 1'b0);
    chk("tmo_rdata_kept", CPU_RData, 8'h11);
    CPU_Write = 1'b0; Mem_Ready = 1'b1;
    tick(); #1;
    chk("tmo_err_sticky", Bus_Error, 1'b1);
    Err_Clr = 1'b1;
    tick(); #1;
    Err_Clr = 1'b0;
    chk("errclr", Bus_Error, 1'b0);

    // Read+Write together with Err_Clr in the grant cycle: write, set wins.
    CPU_Read = 1'b1; CPU_Write = 1'b1; CPU_Addr = 8'h30; CPU_WData = 8'hC3; Err_Clr = 1'b1;
    tick(); #1;
    Err_Clr = 1'b0;
    chk("rw_we", Mem_WE, 1'b1);
    chk("rw_wdata", Mem_WData, 8'hC3);
    chk("rw_set_wins", Bus_Error, 1'b1);
    tick(); #1;
    CPU_Read = 1'b0; CPU_Write = 1'b0; Err_Clr = 1'b1;
    tick(); #1;
    Err_Clr = 1'b0;
    chk("rw_clr", Bus_Error, 1'b0);

    // CPU and debug in the same IDLE; debug drops its request after grant.
    CPU_Read = 1'b1; CPU_Addr = 8'h50; Dbg_Req = 1'b1; Dbg_We = 1'b0; Dbg_Addr = 8'h42;
    Mem_RData = 8'h3E;
    tick(); #1;
    chk("both_cpu_first", Grant_Owner, 2'd1);
    tick(); #1;
    CPU_Read = 1'b0;
    tick(); #1;
    chk("both_idle", Grant_Owner, 2'd0);
    tick(); #1;
    chk("both_dbg_next", Grant_Owner, 2'd2);
    Dbg_Req = 1'b0;
    tick(); #1;
    chk("late_drop_ack", Dbg_Ack, 1'b1);
    chk("late_drop_rdata", Dbg_RData, 8'h3E);
    tick(); #1;

    // Reset in the middle of an access.
    CPU_Read = 1'b1; CPU_Addr = 8'h60; Mem_Ready = 1'b0;
    tick(); #1;
    chk("mid_cs_before", Mem_CS, 1'b1);
    nReset = 1'b0; #1;
    chk("mid_rst_cs", Mem_CS, 1'b0);
    chk("mid_rst_wait", CPU_Wait, 1'b0);
    chk("mid_rst_owner", Grant_Owner, 2'd0);
    chk("mid_rst_rdata", CPU_RData, 8'h00);
    tick(); #1;
    chk("mid_rst_ack", Dbg_Ack, 1'b0);
    tick();
    nReset = 1'b1; Mem_Ready = 1'b1; Mem_RData = 8'h66; #1;
    chk("post_rst_idle", Grant_Owner, 2'd0);
    chk("post_rst_wait", CPU_Wait, 1'b1);
    tick(); #1;
    chk("post_rst_grant", Grant_Owner, 2'd1);
    chk("post_rst_addr", Mem_Addr, 8'h60);
    tick(); #1;
    chk("post_rst_rdata", CPU_RData, 8'h66);
    chk("post_rst_wait_rel", CPU_Wait, 1'b0);
    CPU_Read = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
